// File: rtl/apb_cmd_initiator.sv
// APB requester: turns single-beat valid/ready commands into APB SETUP/ACCESS
// transfers and returns one response per command. Only one transfer is in flight at a time.
module apb_cmd_initiator #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   // Command and response channels: a transfer happens on a PCLK edge where
   // valid & ready are both high; valid, once raised, holds its payload until then.
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam bit          TO_EN     = (TIMEOUT != 0);
   localparam logic [15:0] WAIT_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [15:0] wait_cnt;
   logic        timeout_hit;

   // Completion takes priority: a ready slave on the last allowed cycle is not a timeout.
   assign timeout_hit = TO_EN && !PREADY && (wait_cnt == WAIT_LAST);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cmd_valid) state_d = S_SETUP;
         S_SETUP:  state_d = S_ACCESS;
         S_ACCESS: if (PREADY || timeout_hit) state_d = S_RESP;
         S_RESP:   if (rsp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  PWRITE  <= cmd_write;
                  PADDR   <= cmd_addr;
                  // Reads leave the last write data on the bus.
                  if (cmd_write) PWDATA <= cmd_wdata;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
               end
            end
            S_SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= 16'd0;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
               end else if (wait_cnt != 16'hFFFF) begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator: directed scenarios plus random traffic against a
// transaction-level model (timeline per command, memory-backed slave, expected response queue).
module tb_apb_cmd_initiator;

   localparam int TO = 4;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [5:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [5:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   apb_cmd_initiator #(.ADDR_W(6), .DATA_W(32), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   // ---------------- clock / watchdog ----------------
   always #5 PCLK = ~PCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic        w;
      logic [5:0]  a;
      logic [31:0] d;
      int          waits;
      logic        err;
   } cmd_t;

   int          n_tests = 0;
   int          n_fail = 0;
   cmd_t        drv;
   cmd_t        cur;
   logic [31:0] mem [64];
   logic [31:0] exp_q[$];
   logic [1:0]  exp_trace[$];
   logic        exp_err = 1'b0;
   logic        exp_to = 1'b0;
   int          phase = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          rsp_cyc = 0;
   int          pen_cnt = 0;
   int          acc_idx = 0;
   logic        rsp_seen = 1'b0;
   logic [5:0]  last_addr = '0;
   logic        last_write = 1'b0;
   logic [31:0] last_wdata = '0;
   logic [31:0] got_rdata = '0;
   logic        got_err = 1'b0;
   logic        got_to = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- model, per-cycle compare and slave ----------------
   initial begin
      logic [1:0] e;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h1234ABCD;
      forever begin
         @(posedge PCLK);
         #1;
         cyc++;
         e = 2'b00;
         if (!PRESETn) begin
            phase = 0;
            exp_trace.delete();
            exp_q.delete();
            last_addr = '0;
            last_write = 1'b0;
            last_wdata = '0;
            rsp_seen = 1'b0;
         end else begin
            if (phase == 2 && rsp_ready) begin
               phase = 0;
               void'(exp_q.pop_front());
               done_cnt++;
            end else if (phase == 0 && cmd_valid) begin
               int len;
               cur = drv;
               exp_to = (cur.waits >= TO);
               len = exp_to ? TO : cur.waits + 1;
               exp_err = exp_to | cur.err;
               exp_q.push_back((exp_to || cur.w) ? 32'd0 : mem[cur.a]);
               if (cur.w && !exp_to && !cur.err) mem[cur.a] = cur.d;
               last_addr = cur.a;
               last_write = cur.w;
               if (cur.w) last_wdata = cur.d;
               exp_trace.push_back(2'b10);
               for (int k = 0; k < len; k++) exp_trace.push_back(2'b11);
               phase = 1;
               acc_cnt++;
               acc_cyc = cyc;
               pen_cnt = 0;
            end
            if (phase == 1) begin
               if (exp_trace.size() == 0) begin
                  phase = 2;
                  rsp_cyc = cyc;
                  rsp_seen = 1'b1;
               end else begin
                  e = exp_trace.pop_front();
               end
            end
         end
         if (PENABLE) pen_cnt++;

         chk("psel", 32'(PSEL), 32'(e[1]));
         chk("penable", 32'(PENABLE), 32'(e[0]));
         chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
         chk("busy", 32'(busy), 32'(phase != 0));
         chk("cmd_ready", 32'(cmd_ready), 32'(phase == 0));
         chk("paddr", 32'(PADDR), 32'(last_addr));
         chk("pwrite", 32'(PWRITE), 32'(last_write));
         chk("pwdata", PWDATA, last_wdata);
         if (phase == 2) begin
            chk("rsp_rdata", rsp_rdata, exp_q[0]);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
            got_rdata = rsp_rdata;
            got_err = rsp_err;
            got_to = rsp_timeout;
         end else if (!rsp_seen) begin
            chk("rsp_rdata_rst", rsp_rdata, 32'd0);
            chk("rsp_err_rst", 32'(rsp_err), 32'd0);
            chk("rsp_timeout_rst", 32'(rsp_timeout), 32'd0);
         end

         // Slave: wait cur.waits ACCESS cycles, then complete; noise elsewhere.
         if (PSEL && !PENABLE) acc_idx = 0;
         if (PSEL && PENABLE) begin
            if (acc_idx == cur.waits) begin
               PREADY = 1'b1;
               PSLVERR = cur.err;
               PRDATA = cur.w ? $urandom : mem[PADDR];
            end else begin
               PREADY = 1'b0;
               PSLVERR = 1'($urandom);
               PRDATA = $urandom;
            end
            acc_idx++;
         end else begin
            PREADY = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA = $urandom;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic present(input logic w, input logic [5:0] a, input logic [31:0] d,
                          input int waits, input logic err);
      drv.w = w;
      drv.a = a;
      drv.d = d;
      drv.waits = waits;
      drv.err = err;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr = a;
      cmd_wdata = d;
   endtask

   task automatic wait_accept(input int tgt);
      for (int i = 0; i < 100 && acc_cnt < tgt; i++) @(negedge PCLK);
      chk("accept_wait", 32'(acc_cnt >= tgt), 32'd1);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr = 6'($urandom);
      cmd_wdata = $urandom;
   endtask

   task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input int waits, input logic err);
      int tgt;
      @(negedge PCLK);
      tgt = acc_cnt + 1;
      present(w, a, d, waits, err);
      wait_accept(tgt);
   endtask

   task automatic finish_rsp(input int rmode);
      int tgt;
      tgt = done_cnt + 1;
      for (int i = 0; i < 200 && done_cnt < tgt; i++) begin
         rsp_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge PCLK);
      end
      chk("rsp_wait", 32'(done_cnt >= tgt), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int tgt;
      repeat (3) @(negedge PCLK);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      PRESETn = 1'b1;
      rsp_ready = 1'b1;

      // 1: zero-wait write
      issue(1'b1, 6'h04, 32'hDEADBEEF, 0, 1'b0);
      finish_rsp(0);
      chk("t1_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
      chk("t1_rdata", got_rdata, 32'd0);
      chk("t1_err", 32'(got_err), 32'd0);

      // 2: read with 3 wait states
      issue(1'b0, 6'h00, 32'h0, 3, 1'b0);
      finish_rsp(0);
      chk("t2_rdata", got_rdata, 32'h1234ABCD);
      chk("t2_access_len", 32'(pen_cnt), 32'd4);
      chk("t2_latency", 32'(rsp_cyc - acc_cyc), 32'd5);

      // 3: slave error on completion (random PSLVERR noise during waits)
      issue(1'b0, 6'h08, 32'h0, 2, 1'b1);
      finish_rsp(0);
      chk("t3_err", 32'(got_err), 32'd1);
      chk("t3_timeout", 32'(got_to), 32'd0);
      issue(1'b0, 6'h09, 32'h0, 3, 1'b0);
      finish_rsp(0);
      chk("t3_noise_err", 32'(got_err), 32'd0);

      // 4: timeout, then completion on the last allowed cycle
      issue(1'b0, 6'h01, 32'h0, 100, 1'b0);
      finish_rsp(0);
      chk("t4_to_rdata", got_rdata, 32'd0);
      chk("t4_to_err", 32'(got_err), 32'd1);
      chk("t4_to_flag", 32'(got_to), 32'd1);
      chk("t4_to_len", 32'(pen_cnt), 32'd4);
      chk("t4_to_latency", 32'(rsp_cyc - acc_cyc), 32'd5);
      issue(1'b0, 6'h01, 32'h0, 3, 1'b0);
      finish_rsp(0);
      chk("t4_edge_flag", 32'(got_to), 32'd0);
      chk("t4_edge_rdata", got_rdata, mem[1]);

      // 5: second command held while first response is stalled
      rsp_ready = 1'b0;
      issue(1'b1, 6'h10, 32'hFFFF0000, 0, 1'b0);
      tgt = acc_cnt + 1;
      present(1'b0, 6'h10, 32'h0, 1, 1'b0);
      for (int i = 0; i < 20 && phase != 2; i++) @(negedge PCLK);
      chk("t5_rsp_reached", 32'(phase), 32'd2);
      repeat (5) @(negedge PCLK);
      chk("t5_held_off", 32'(acc_cnt), 32'(tgt - 1));
      rsp_ready = 1'b1;
      wait_accept(tgt);
      finish_rsp(0);
      chk("t5_rdata", got_rdata, 32'hFFFF0000);

      // 6: asynchronous reset during ACCESS
      issue(1'b0, 6'h05, 32'h0, 3, 1'b0);
      @(negedge PCLK);
      chk("t6_in_access", 32'(PENABLE), 32'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("t6_psel", 32'(PSEL), 32'd0);
      chk("t6_penable", 32'(PENABLE), 32'd0);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      issue(1'b0, 6'h00, 32'h0, 1, 1'b0);
      finish_rsp(0);
      chk("t6_after_rdata", got_rdata, 32'h1234ABCD);

      // random traffic
      for (int n = 0; n < 40; n++) begin
         int r;
         int waits;
         r = $urandom_range(0, 9);
         waits = (r < 6) ? (r % 4) : ((r < 8) ? 3 : 4 + r);
         issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom, waits,
               ($urandom_range(0, 3) == 0));
         finish_rsp(1);
      end

      rsp_ready = 1'b1;
      repeat (3) @(negedge PCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
